// File: rtl/cmsdk_mcu_mtx4x2_in_s1_if.sv
// ---------------------------------------------------------------------------
// cmsdk_mcu_mtx4x2_in_s1_if
// Signal bundle for the bus-matrix input stage.
//   Slave-port side (AHB from the master):
//     HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS : address phase in
//     HREADYS                                                  : bus HREADY in
//     HREADYOUTS, HRESPS                                       : response out
//     HAUSERS (only with CMSDK_MTX_IN_AUSER_EN)                : address user bits
//   Decode-stage side:
//     sel_in, addr_in, trans_in, write_in, size_in, burst_in,
//     prot_in, auser_in                                        : address phase out
//     ready_in, held_tran_in                                   : HREADY / held flag out
//     active_in, readyout_in, resp_in                          : decode-stage feedback
// Handshake semantics: an address phase is accepted by the bus when HSELS,
// HREADYS and HTRANSS[1] are all high at a rising clock edge. If the decode
// stage is not active for it (active_in=0) the input stage stores it and
// stalls the master (HREADYOUTS=0) until the decode stage reports active_in=1;
// the stored transfer is consumed at that edge.
// Modports: slave = the input stage, master = whatever drives/observes it.
// Optional feature macro: CMSDK_MTX_IN_AUSER_EN adds HAUSERS.
// ---------------------------------------------------------------------------
interface cmsdk_mcu_mtx4x2_in_s1_if;
  logic        HSELS;
  logic [31:0] HADDRS;
  logic [1:0]  HTRANSS;
  logic        HWRITES;
  logic [2:0]  HSIZES;
  logic [2:0]  HBURSTS;
  logic [3:0]  HPROTS;
  logic        HREADYS;
  logic        HREADYOUTS;
  logic [1:0]  HRESPS;
`ifdef CMSDK_MTX_IN_AUSER_EN
  logic [2:0]  HAUSERS;
`endif
  logic        sel_in;
  logic [31:0] addr_in;
  logic [1:0]  trans_in;
  logic        write_in;
  logic [2:0]  size_in;
  logic [2:0]  burst_in;
  logic [3:0]  prot_in;
  logic [2:0]  auser_in;
  logic        ready_in;
  logic        held_tran_in;
  logic        active_in;
  logic        readyout_in;
  logic [1:0]  resp_in;

  modport slave (
`ifdef CMSDK_MTX_IN_AUSER_EN
    input  HAUSERS,
`endif
    input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HREADYS,
    output HREADYOUTS, HRESPS,
    output sel_in, addr_in, trans_in, write_in, size_in, burst_in, prot_in,
    output auser_in, ready_in, held_tran_in,
    input  active_in, readyout_in, resp_in
  );

  modport master (
`ifdef CMSDK_MTX_IN_AUSER_EN
    output HAUSERS,
`endif
    output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HREADYS,
    input  HREADYOUTS, HRESPS,
    input  sel_in, addr_in, trans_in, write_in, size_in, burst_in, prot_in,
    input  auser_in, ready_in, held_tran_in,
    output active_in, readyout_in, resp_in
  );
endinterface

// File: rtl/cmsdk_mcu_mtx4x2_in_s1.sv
// ---------------------------------------------------------------------------
// cmsdk_mcu_mtx4x2_in_s1
// Bus-matrix input stage for slave port S1. Passes the AHB address phase to
// the decode stage with zero latency, or, when the decode stage cannot take a
// new transfer yet, holds it and re-presents it as a NONSEQ later.
// Ports:
//   HCLK   : clock, all state updates on the rising edge
//   HRESET : synchronous active-high reset
//   bus    : cmsdk_mcu_mtx4x2_in_s1_if.slave (AHB slave port + decode side)
// Optional feature macro: CMSDK_MTX_IN_AUSER_EN carries HAUSERS through to
// auser_in (held and muxed like HADDRS); without it auser_in is 3'b000.
// The hold state is visible on bus.held_tran_in (high exactly in ST_HOLD).
// ---------------------------------------------------------------------------
module cmsdk_mcu_mtx4x2_in_s1 (
  input logic                          HCLK,
  input logic                          HRESET,
  cmsdk_mcu_mtx4x2_in_s1_if.slave      bus
);

  typedef enum logic {
    ST_PASS = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic        write_q;
  logic [2:0]  size_q;
  logic [2:0]  burst_q;
  logic [3:0]  prot_q;
  logic [2:0]  auser_q;
  logic [2:0]  auser_live;
  logic        new_tran;
  logic        pend_tran;

`ifdef CMSDK_MTX_IN_AUSER_EN
  assign auser_live = bus.HAUSERS;
`else
  assign auser_live = 3'b000;
`endif

  // Only NONSEQ/SEQ are real transfers; IDLE and BUSY are never stored.
  assign new_tran  = bus.HSELS & bus.HREADYS & bus.HTRANSS[1];
  assign pend_tran = (state == ST_HOLD);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state   <= ST_PASS;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      burst_q <= '0;
      prot_q  <= '0;
      auser_q <= '0;
    end else begin
      case (state)
        ST_PASS: begin
          if (new_tran && !bus.active_in) begin
            state   <= ST_HOLD;
            addr_q  <= bus.HADDRS;
            write_q <= bus.HWRITES;
            size_q  <= bus.HSIZES;
            burst_q <= bus.HBURSTS;
            prot_q  <= bus.HPROTS;
            auser_q <= auser_live;
          end
        end
        ST_HOLD: begin
          // New transfers are ignored here: the master is stalled by
          // HREADYOUTS=0, and the holding registers keep the stored one.
          if (bus.active_in) begin
            state <= ST_PASS;
          end
        end
        default: state <= ST_PASS;
      endcase
    end
  end

  // A held transfer is re-issued as NONSEQ: a SEQ that was stalled loses its
  // burst context on the decode side, so it must restart as a new transfer.
  always_comb begin
    if (pend_tran) begin
      bus.sel_in       = 1'b1;
      bus.addr_in      = addr_q;
      bus.trans_in     = 2'b10;
      bus.write_in     = write_q;
      bus.size_in      = size_q;
      bus.burst_in     = burst_q;
      bus.prot_in      = prot_q;
      bus.ready_in     = 1'b1;
      bus.held_tran_in = 1'b1;
      bus.HREADYOUTS   = 1'b0;
      bus.HRESPS       = 2'b00;
    end else begin
      bus.sel_in       = bus.HSELS;
      bus.addr_in      = bus.HADDRS;
      bus.trans_in     = bus.HTRANSS;
      bus.write_in     = bus.HWRITES;
      bus.size_in      = bus.HSIZES;
      bus.burst_in     = bus.HBURSTS;
      bus.prot_in      = bus.HPROTS;
      bus.ready_in     = bus.HREADYS;
      bus.held_tran_in = 1'b0;
      bus.HREADYOUTS   = bus.readyout_in;
      bus.HRESPS       = bus.resp_in;
    end
  end

`ifdef CMSDK_MTX_IN_AUSER_EN
  assign bus.auser_in = pend_tran ? auser_q : auser_live;
`else
  // auser_q stays at reset value when the feature is off; the output is tied.
  logic unused_auser;
  assign unused_auser = ^auser_q;
  assign bus.auser_in = 3'b000;
`endif

endmodule
